// File: rtl/hit_manager.sv
// Frame-level hit detection, HP and invulnerability tracking for the heart sprite.
// Optional heart blink during invulnerability: define HIT_BLINK_EN.
module hit_manager #(
    parameter int HP_MAX        = 20,
    parameter int DAMAGE        = 3,
    parameter int MIN_OVERLAP   = 4,
    parameter int INVULN_FRAMES = 30
) (
    input  logic       Pclk,
    input  logic       reset,
    input  logic       isCollision,
    input  logic       frame_end,
    input  logic       game_start,
    output logic [7:0] hp,
    output logic       hit_pulse,
    output logic       invuln,
    output logic       heart_visible,
    output logic       game_over,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        PLAY   = 2'b01,
        INVULN = 2'b10,
        DEAD   = 2'b11
    } state_e;

    localparam logic [7:0] HP_INIT = 8'(HP_MAX);
    localparam logic [7:0] DMG     = 8'(DAMAGE);
    localparam logic [9:0] MIN_OV  = 10'(MIN_OVERLAP);
    localparam logic [7:0] INV_TMR = 8'(INVULN_FRAMES);

    state_e     state_q, state_d;
    logic [7:0] hp_q, hp_d;
    logic [9:0] cnt_q, cnt_d;
    logic [7:0] timer_q, timer_d;
    logic       hit_pulse_q, hit_pulse_d;
    logic       invuln_q, invuln_d;

    logic [9:0] cnt_now;
    logic [8:0] hp_sub;
    logic [7:0] hp_hit;
    logic       qualify;

    // Current cycle's collision counts toward the frame closing on this cycle
    always_comb begin
        cnt_now = cnt_q;
        if (isCollision && cnt_q != 10'h3FF) begin
            cnt_now = cnt_q + 10'd1;
        end
        hp_sub  = {1'b0, hp_q} - {1'b0, DMG};
        hp_hit  = hp_sub[8] ? 8'd0 : hp_sub[7:0];
        qualify = (cnt_now >= MIN_OV);
    end

    always_ff @(posedge Pclk) begin
        if (reset) begin
            state_q     <= IDLE;
            hp_q        <= HP_INIT;
            cnt_q       <= 10'd0;
            timer_q     <= 8'd0;
            hit_pulse_q <= 1'b0;
            invuln_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            hp_q        <= hp_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            hit_pulse_q <= hit_pulse_d;
            invuln_q    <= invuln_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (game_start) begin
            state_d = PLAY;
        end else if (frame_end) begin
            unique case (state_q)
                PLAY: begin
                    if (qualify) begin
                        state_d = (hp_hit == 8'd0) ? DEAD : INVULN;
                    end
                end
                INVULN: begin
                    if (timer_q <= 8'd1) begin
                        state_d = PLAY;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        hp_d        = hp_q;
        cnt_d       = frame_end ? 10'd0 : cnt_now;
        timer_d     = timer_q;
        hit_pulse_d = 1'b0;
        if (game_start) begin
            hp_d    = HP_INIT;
            timer_d = 8'd0;
            cnt_d   = 10'd0;
        end else if (frame_end) begin
            unique case (state_q)
                PLAY: begin
                    if (qualify) begin
                        hp_d        = hp_hit;
                        hit_pulse_d = 1'b1;
                        timer_d     = INV_TMR;
                    end
                end
                INVULN: begin
                    timer_d = (timer_q == 8'd0) ? 8'd0 : timer_q - 8'd1;
                end
                default: timer_d = timer_q;
            endcase
        end
        invuln_d = (state_d == INVULN);
    end

`ifdef HIT_BLINK_EN
    logic [1:0] blink_q, blink_d;

    // Cleared on entry so the heart starts hidden on the first invulnerable frame
    always_comb begin
        blink_d = blink_q;
        if (state_d == INVULN && state_q != INVULN) begin
            blink_d = 2'd0;
        end else if (state_q == INVULN && frame_end) begin
            blink_d = blink_q + 2'd1;
        end
    end

    always_ff @(posedge Pclk) begin
        if (reset) begin
            blink_q <= 2'd0;
        end else begin
            blink_q <= blink_d;
        end
    end

    assign heart_visible = (state_q == INVULN) ? blink_q[1] : 1'b1;
`else
    assign heart_visible = 1'b1;
`endif

    always_comb begin
        hp        = hp_q;
        hit_pulse = hit_pulse_q;
        invuln    = invuln_q;
        game_over = (state_q == DEAD);
        state_dbg = state_q;
    end

endmodule

// File: tb/tb_hit_manager.sv
// Self-checking bench: two hit_manager instances (HP_MAX 20 and 5) on shared
// stimulus, compared every cycle against a frame-level behavioural model.
module tb_hit_manager;

    logic       Pclk = 1'b0;
    logic       reset = 1'b1;
    logic       isCollision = 1'b0;
    logic       frame_end = 1'b0;
    logic       game_start = 1'b0;

    logic [7:0] hp_a, hp_b;
    logic       hit_a, hit_b, inv_a, inv_b, hv_a, hv_b, go_a, go_b;
    logic [1:0] st_a, st_b;

    int checks = 0;
    int failures = 0;

    always #20 Pclk = ~Pclk;

    hit_manager #(.HP_MAX(20), .DAMAGE(3), .MIN_OVERLAP(4), .INVULN_FRAMES(30)) dut_a (
        .Pclk(Pclk), .reset(reset), .isCollision(isCollision),
        .frame_end(frame_end), .game_start(game_start),
        .hp(hp_a), .hit_pulse(hit_a), .invuln(inv_a),
        .heart_visible(hv_a), .game_over(go_a), .state_dbg(st_a)
    );

    hit_manager #(.HP_MAX(5), .DAMAGE(3), .MIN_OVERLAP(4), .INVULN_FRAMES(30)) dut_b (
        .Pclk(Pclk), .reset(reset), .isCollision(isCollision),
        .frame_end(frame_end), .game_start(game_start),
        .hp(hp_b), .hit_pulse(hit_b), .invuln(inv_b),
        .heart_visible(hv_b), .game_over(go_b), .state_dbg(st_b)
    );

`ifdef HIT_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    // Model: mode 0 idle, 1 playing, 2 invulnerable, 3 dead
    int m_hpmax[2] = '{20, 5};
    int m_mode[2], m_hp[2], m_cnt[2], m_left[2], m_blink[2], m_hit[2];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int i, input bit r, input bit c, input bit fe, input bit gs);
        int total;
        if (r) begin
            m_mode[i] = 0; m_hp[i] = m_hpmax[i]; m_cnt[i] = 0;
            m_left[i] = 0; m_blink[i] = 0; m_hit[i] = 0;
            return;
        end
        total = m_cnt[i] + (c ? 1 : 0);
        if (total > 1023) total = 1023;
        m_hit[i] = 0;
        if (gs) begin
            m_mode[i] = 1; m_hp[i] = m_hpmax[i]; m_left[i] = 0; m_cnt[i] = 0;
        end else if (fe) begin
            if (m_mode[i] == 1 && total >= 4) begin
                m_hp[i] = (m_hp[i] > 3) ? m_hp[i] - 3 : 0;
                m_hit[i] = 1;
                if (m_hp[i] == 0) m_mode[i] = 3;
                else begin
                    m_mode[i] = 2; m_left[i] = 30; m_blink[i] = 0;
                end
            end else if (m_mode[i] == 2) begin
                m_left[i]--;
                m_blink[i] = (m_blink[i] + 1) % 4;
                if (m_left[i] == 0) m_mode[i] = 1;
            end
            m_cnt[i] = 0;
        end else begin
            m_cnt[i] = total;
        end
    endtask

    function automatic int exp_heart(input int i);
        if (BLINK && m_mode[i] == 2) return (m_blink[i] >= 2) ? 1 : 0;
        return 1;
    endfunction

    task automatic compare_all();
        check("a_hp", hp_a, m_hp[0]);
        check("a_hit", hit_a, m_hit[0]);
        check("a_invuln", inv_a, m_mode[0] == 2);
        check("a_gameover", go_a, m_mode[0] == 3);
        check("a_state", st_a, m_mode[0]);
        check("a_heart", hv_a, exp_heart(0));
        check("b_hp", hp_b, m_hp[1]);
        check("b_hit", hit_b, m_hit[1]);
        check("b_invuln", inv_b, m_mode[1] == 2);
        check("b_gameover", go_b, m_mode[1] == 3);
        check("b_state", st_b, m_mode[1]);
        check("b_heart", hv_b, exp_heart(1));
    endtask

    task automatic step(input bit r, input bit c, input bit fe, input bit gs);
        reset = r; isCollision = c; frame_end = fe; game_start = gs;
        @(posedge Pclk);
        #1;
        model_step(0, r, c, fe, gs);
        model_step(1, r, c, fe, gs);
        compare_all();
        reset = 1'b0; isCollision = 1'b0; frame_end = 1'b0; game_start = 1'b0;
    endtask

    // n collision cycles, then a frame_end with collision value cfe
    task automatic frame(input int n, input bit cfe);
        for (int k = 0; k < n; k++) step(0, 1, 0, 0);
        step(0, cfe, 1, 0);
    endtask

    initial begin
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("lit_reset_hp", hp_a, 20);
        check("lit_reset_state", st_a, 0);
        check("lit_reset_heart", hv_a, 1);

        step(0, 0, 0, 1);
        frame(3, 0);
        check("lit_sub_thresh_hit", hit_a, 0);
        check("lit_sub_thresh_hp", hp_a, 20);
        check("lit_sub_thresh_state", st_a, 1);

        frame(3, 1);
        check("lit_hit_pulse", hit_a, 1);
        check("lit_hit_hp_a", hp_a, 17);
        check("lit_hit_hp_b", hp_b, 2);
        check("lit_hit_invuln", inv_a, 1);
        check("lit_blink_first", hv_a, BLINK ? 0 : 1);
        step(0, 0, 0, 0);
        check("lit_hit_pulse_end", hit_a, 0);

        for (int f = 0; f < 30; f++) frame(5, 1);
        check("lit_post_inv_state", st_a, 1);
        check("lit_post_inv_hp", hp_a, 17);
        check("lit_post_inv_heart", hv_a, 1);

        frame(4, 1);
        check("lit_b_clamp_hp", hp_b, 0);
        check("lit_b_dead", go_b, 1);
        check("lit_b_state", st_b, 3);
        for (int f = 0; f < 3; f++) frame(6, 1);
        check("lit_b_dead_hold", hp_b, 0);

        step(0, 0, 0, 1);
        check("lit_restart_hp", hp_b, 5);
        check("lit_restart_go", go_b, 0);
        check("lit_restart_state", st_b, 1);
        frame(4, 0);
        check("lit_restart_hit_hp", hp_a, 17);

        step(0, 0, 0, 1);
        for (int k = 0; k < 10; k++) step(0, 1, 0, 0);
        step(0, 0, 1, 1);
        step(0, 0, 0, 0);
        check("lit_gs_fe_hit", hit_a, 0);
        check("lit_gs_fe_hp", hp_a, 20);
        frame(3, 0);
        check("lit_cnt_cleared", hp_a, 20);

        for (int f = 0; f < 400; f++) begin
            int len = $urandom_range(2, 12);
            int pct = $urandom_range(0, 100);
            for (int k = 0; k < len; k++) begin
                bit r = ($urandom_range(0, 1499) == 0);
                bit g = ($urandom_range(0, 299) == 0);
                step(r, ($urandom_range(0, 99) < pct), 0, g);
            end
            step(0, ($urandom_range(0, 99) < pct), 1, ($urandom_range(0, 49) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
